// File: rtl/gpr_file_sb.sv
// ============================================================================
// Module   : gpr_file_sb
// Brief    : MIPS GPR file with 2 read ports, bypassed write port, hardwired
//            zero register, post-reset clear engine and pending-write
//            scoreboard. Optional write trace enabled by macro GPR_TRACE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpr_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] reg_rs,
    output logic [DATA_W-1:0] reg_rt,
    output logic              rs_pend,
    output logic              rt_pend,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              init_busy
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_idx_last = ADDR_W'(c_depth - 1);
    localparam logic [ADDR_W-1:0] c_idx_one  = ADDR_W'(1);
    localparam bit                c_zero_en  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_gpr [c_depth];
    logic [c_depth-1:0]  r_pend;

    logic w_clear_step;
    logic w_run;
    logic w_wr_ok;
    logic w_iss_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clear_step = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear_step = !rst;
                if (r_idx == c_idx_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = !rst;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // Register 0 writes and issues are discarded entirely when hardwired.
    assign w_wr_ok  = w_run && w_en   && !(c_zero_en && (w_addr   == '0));
    assign w_iss_ok = w_run && iss_en && !(c_zero_en && (iss_addr == '0));
    assign init_busy = (r_state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_clear_step) begin
            r_idx <= r_idx + c_idx_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear_step) begin
            r_gpr[r_idx] <= '0;
        end else if (w_wr_ok) begin
            r_gpr[w_addr] <= w_data;
        end
    end

    // Issue is applied after the write clear so a newer producer keeps the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_pend[w_addr] <= 1'b0;
            end
            if (w_iss_ok) begin
                r_pend[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_rp;
        logic              w_hit;

        assign w_ra  = (p == 0) ? rs_addr : rt_addr;
        assign w_hit = w_en && (w_addr == w_ra);

        always_comb begin
            w_rd = '0;
            w_rp = 1'b0;
            if (r_state == ST_RUN) begin
                if (c_zero_en && (w_ra == '0)) begin
                    w_rd = '0;
                end else if (w_hit) begin
                    w_rd = w_data;
                end else begin
                    w_rd = r_gpr[w_ra];
                end
                w_rp = r_pend[w_ra] && !w_hit;
            end
        end
    end

    assign reg_rs  = g_rd_port[0].w_rd;
    assign reg_rt  = g_rd_port[1].w_rd;
    assign rs_pend = g_rd_port[0].w_rp;
    assign rt_pend = g_rd_port[1].w_rp;

`ifdef GPR_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            $display("R[%2d]=%8X", w_addr, w_data);
        end
        if (w_clear_step && (r_idx == c_idx_last)) begin
            $display("GPR init done");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_sb.sv
// ============================================================================
// Module   : tb_gpr_file_sb
// Brief    : Directed self-checking bench for gpr_file_sb (default and small
//            ZERO_REG=0 configurations) with a queue-based scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpr_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 32 x 32, register 0 hardwired.
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, w_addr, iss_addr;
    logic [31:0] reg_rs, reg_rt, w_data;
    logic        rs_pend, rt_pend, w_en, iss_en, init_busy;

    // Small configuration: 8 x 16, register 0 ordinary.
    logic        rst_b;
    logic [2:0]  rs_addr_b, rt_addr_b, w_addr_b, iss_addr_b;
    logic [15:0] reg_rs_b, reg_rt_b, w_data_b;
    logic        rs_pend_b, rt_pend_b, w_en_b, iss_en_b, init_busy_b;

    gpr_file_sb u_dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_rs(reg_rs), .reg_rt(reg_rt),
        .rs_pend(rs_pend), .rt_pend(rt_pend),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .init_busy(init_busy)
    );

    gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .rs_addr(rs_addr_b), .rt_addr(rt_addr_b),
        .reg_rs(reg_rs_b), .reg_rt(reg_rt_b),
        .rs_pend(rs_pend_b), .rt_pend(rt_pend_b),
        .w_en(w_en_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .iss_en(iss_en_b), .iss_addr(iss_addr_b),
        .init_busy(init_busy_b)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles starting in the cycle where reset was just released.
    task automatic count_busy(input bit sel_b, output int cnt);
        cnt = 0;
        while (((sel_b ? init_busy_b : init_busy) === 1'b1) && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    int busy_cnt;

    initial begin
        rst = 1'b1; rs_addr = '0; rt_addr = '0; w_en = 1'b0; w_addr = '0;
        w_data = '0; iss_en = 1'b0; iss_addr = '0;
        rst_b = 1'b1; rs_addr_b = '0; rt_addr_b = '0; w_en_b = 1'b0;
        w_addr_b = '0; w_data_b = '0; iss_en_b = 1'b0; iss_addr_b = '0;
        #1;

        // Reset state
        repeat (3) step();
        rs_addr = 5'd4; rt_addr = 5'd4; #1;
        check("rst_busy", {31'd0, init_busy}, 32'd1);
        check("rst_reg_rs", reg_rs, 32'd0);
        check("rst_pend", {30'd0, rs_pend, rt_pend}, 32'd0);

        // Release reset; writes/issues during CLEAR must be ignored
        rst = 1'b0;
        w_en = 1'b1; w_addr = 5'd4; w_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd4; #1;
        check("clear_bypass_forced0", reg_rs, 32'd0);
        check("clear_pend_forced0", {31'd0, rs_pend}, 32'd0);
        count_busy(1'b0, busy_cnt);
        w_en = 1'b0; iss_en = 1'b0;
        check("clear_len", busy_cnt, 32'd32);

        // All registers read 0 after clear
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
            check($sformatf("clr_rs_R%0d", i), reg_rs, 32'd0);
            check($sformatf("clr_rt_R%0d", 31 - i), reg_rt, 32'd0);
        end
        rs_addr = 5'd4; #1;
        check("clear_iss_ignored", {31'd0, rs_pend}, 32'd0);

        // Write/read and zero register
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        w_addr = 5'd0; w_data = 32'h1234_5678;
        exp_q.push_back(32'h0000_0000);
        step();
        w_en = 1'b0; rs_addr = 5'd5; rt_addr = 5'd0; #1;
        check_pop("rd_R5", reg_rs);
        check_pop("rd_R0_zero", reg_rt);

        // Bypass: stored value vs same-cycle write data
        w_en = 1'b1; w_addr = 5'd9; w_data = 32'h1111_1111;
        step();
        w_en = 1'b0; rs_addr = 5'd9; rt_addr = 5'd9; #1;
        check("bypass_old_R9", reg_rs, 32'h1111_1111);
        w_en = 1'b1; w_data = 32'hA5A5_A5A5; #1;
        check("bypass_rs", reg_rs, 32'hA5A5_A5A5);
        check("bypass_rt", reg_rt, 32'hA5A5_A5A5);
        exp_q.push_back(32'hA5A5_A5A5);
        step();
        w_en = 1'b0; #1;
        check_pop("bypass_stored", reg_rs);

        // Scoreboard: issue, resolve, simultaneous set-wins
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        iss_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd7; #1;
        check("pend_set_rs", {31'd0, rs_pend}, 32'd1);
        check("pend_set_rt", {31'd0, rt_pend}, 32'd1);
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h77; #1;
        check("pend_drop_same_cycle", {31'd0, rs_pend}, 32'd0);
        step();
        w_en = 1'b0; #1;
        check("pend_cleared", {31'd0, rs_pend}, 32'd0);
        w_en = 1'b1; w_data = 32'h78; iss_en = 1'b1; iss_addr = 5'd7; #1;
        check("set_wins_bypass", reg_rs, 32'h78);
        check("set_wins_flag_drop", {31'd0, rs_pend}, 32'd0);
        exp_q.push_back(32'h78);
        step();
        w_en = 1'b0; iss_en = 1'b0; #1;
        check("set_wins_pend", {31'd0, rs_pend}, 32'd1);
        check_pop("set_wins_data", reg_rs);
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        iss_en = 1'b0; rs_addr = 5'd0; #1;
        check("zero_never_pend", {31'd0, rs_pend}, 32'd0);

        // Mid-run reset with R3=0x11 pending
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h11; iss_en = 1'b1; iss_addr = 5'd3;
        step();
        w_en = 1'b0; iss_en = 1'b0; rs_addr = 5'd3; #1;
        check("pre_rst_R3", reg_rs, 32'h11);
        check("pre_rst_pend", {31'd0, rs_pend}, 32'd1);
        rst = 1'b1;
        step();
        check("midrst_busy", {31'd0, init_busy}, 32'd1);
        check("midrst_rd0", reg_rs, 32'd0);
        rst = 1'b0;
        count_busy(1'b0, busy_cnt);
        check("midrst_clear_len", busy_cnt, 32'd32);
        #1;
        check("post_rst_R3", reg_rs, 32'd0);
        check("post_rst_pend", {31'd0, rs_pend}, 32'd0);
        rs_addr = 5'd5; #1;
        check("post_rst_R5", reg_rs, 32'd0);

        // Small configuration, ordinary register 0
        rst_b = 1'b0;
        count_busy(1'b1, busy_cnt);
        check("b_clear_len", busy_cnt, 32'd8);
        w_en_b = 1'b1; w_addr_b = 3'd0; w_data_b = 16'hBEEF;
        exp_q.push_back(32'h0000_BEEF);
        iss_en_b = 1'b1; iss_addr_b = 3'd0;
        step();
        w_en_b = 1'b0; iss_en_b = 1'b0; rs_addr_b = 3'd0; rt_addr_b = 3'd7; #1;
        check_pop("b_R0", {16'd0, reg_rs_b});
        check("b_R0_pend", {31'd0, rs_pend_b}, 32'd1);
        check("b_R7", {16'd0, reg_rt_b}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
